// File: rtl/keypad_in_ctrl.sv
// Keypad input controller: scans a 4x4 active-low matrix, debounces one key
// at a time and assembles hex digits into a 16-bit entry buffer. The commit
// key publishes the buffer to read_data and raises key_ready until the CPU
// reads it (kctrl).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no key held, waiting for a single key in a frame
// DEBOUNCE | candidate key seen, counting identical frames
// ACCEPT   | one clk: key_code and the key action are applied
// PRESSED  | key accepted and still held; no auto-repeat
// RELEASE  | key gone, counting empty frames before re-arming
module keypad_in_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        kctrl,
  input  logic        kclr,
  output logic [15:0] read_data,
  output logic        key_ready,
  output logic [15:0] buf_data,
  output logic [3:0]  key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_ACCEPT, S_PRESSED, S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       cand_q, cand_d;

  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_idx_q;
  logic             slot_end, frame_end;

  // Low-row tally for the frame so far: 0 = none, 1 = one key, 2 = several.
  logic [1:0]       acc_n_q, slot_n, frame_n;
  logic [3:0]       acc_key_q, frame_key;
  logic [1:0]       slot_r;
  logic             frame_hit, frame_none;
  logic             accept;

  assign slot_end  = (div_q == DIV_LAST);
  assign frame_end = slot_end && (col_idx_q == 2'd3);
  assign col       = ~(4'b0001 << col_idx_q);

  // Column slot timer and column index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
    end else if (slot_end) begin
      div_q     <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      div_q     <= div_q + DIV_W'(1);
    end
  end

  // Count low rows in the current slot and remember the (last) low row.
  always_comb begin
    slot_n = 2'd0;
    slot_r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row[i]) begin
        slot_r = 2'(i);
        if (slot_n != 2'd2) slot_n = slot_n + 2'd1;
      end
    end
  end

  // Merge this slot's sample into the frame tally; code is {row, col}.
  always_comb begin
    frame_n   = 2'd2;
    frame_key = acc_key_q;
    if (acc_n_q == 2'd0) begin
      frame_n   = slot_n;
      frame_key = {slot_r, col_idx_q};
    end else if (slot_n == 2'd0) begin
      frame_n   = acc_n_q;
    end
  end

  assign frame_hit  = frame_end && (frame_n == 2'd1);
  assign frame_none = frame_end && (frame_n != 2'd1);

  // Frame tally register, sampled on the last clk of each slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_n_q   <= 2'd0;
      acc_key_q <= 4'h0;
    end else if (frame_end) begin
      acc_n_q   <= 2'd0;
      acc_key_q <= 4'h0;
    end else if (slot_end) begin
      acc_n_q   <= frame_n;
      acc_key_q <= frame_key;
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Debounce FSM next state, advanced only on frame results.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    cnt_inc = cnt_q + CNT_ONE;
    case (state_q)
      S_IDLE: begin
        if (frame_hit) begin
          cand_d = frame_key;
          if (CNT_ONE >= CNT_DONE) begin
            state_d = S_ACCEPT;
            cnt_d   = '0;
          end else begin
            state_d = S_DEBOUNCE;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (frame_hit && (frame_key == cand_q)) begin
          if (cnt_inc == CNT_DONE) begin
            state_d = S_ACCEPT;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end else if (frame_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_ACCEPT: begin
        state_d = S_PRESSED;
        cnt_d   = '0;
      end
      S_PRESSED: begin
        if (frame_none) begin
          if (CNT_ONE >= CNT_DONE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_RELEASE;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_RELEASE: begin
        if (frame_none) begin
          if (cnt_inc == CNT_DONE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end else if (frame_hit) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign accept = (state_q == S_ACCEPT);

  // Key actions and CPU strobes; kclr beats a digit, commit beats kctrl.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data  <= 16'h0000;
      read_data <= 16'h0000;
      key_ready <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      if (accept) key_code <= cand_q;

      if (accept && (cand_q == 4'hE)) begin
        read_data <= buf_data;
        key_ready <= 1'b1;
      end else if (kctrl) begin
        key_ready <= 1'b0;
      end

      if (kclr) begin
        buf_data <= 16'h0000;
      end else if (accept) begin
        if (cand_q == 4'hE)      buf_data <= 16'h0000;
        else if (cand_q == 4'hF) buf_data <= {4'h0, buf_data[15:4]};
        else                     buf_data <= {buf_data[11:0], cand_q};
      end
    end
  end

endmodule

// File: tb/tb_keypad_in_ctrl.sv
// Bench for keypad_in_ctrl: a keypad model drives rows from the column drive,
// a frame-level reference model predicts key actions, and a monitor compares
// the DUT against expected output snapshots queued by the stimulus.
module tb_keypad_in_ctrl;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row, col;
  logic        kctrl = 1'b0, kclr = 1'b0;
  logic [15:0] read_data, buf_data;
  logic        key_ready;
  logic [3:0]  key_code;
  logic [15:0] keys = 16'h0000;

  int cyc;
  int n_cmp = 0;
  int n_err = 0;

  keypad_in_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .kctrl(kctrl), .kclr(kclr),
    .read_data(read_data), .key_ready(key_ready), .buf_data(buf_data),
    .key_code(key_code)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; edge k ends frame k/FR when k%FR==0.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Keypad: a held key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[4*r +: 4] & ~col);
  end

  typedef struct {
    int          t;
    logic [15:0] b;
    logic [15:0] r;
    logic        rdy;
    logic [3:0]  kc;
  } exp_t;
  exp_t q[$];

  logic [15:0] m_buf, m_read;
  logic        m_ready;
  logic [3:0]  m_code;
  bit          armed, pend_v;
  int          none_run, run_len;
  logic [3:0]  run_key, pend_code;

  task automatic model_reset();
    m_buf = 0; m_read = 0; m_ready = 0; m_code = 0;
    armed = 1; pend_v = 0; none_run = 0; run_len = 0; run_key = 0; pend_code = 0;
  endtask

  // One frame result: a key needs DB identical single-key frames starting
  // from the armed state; re-arming needs DB empty frames after an accept.
  task automatic model_frame(input logic [15:0] mask);
    bit hit;
    logic [3:0] k;
    hit = ($countones(mask) == 1);
    k = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = 4'(i);
    if (!armed) begin
      if (!hit) begin
        none_run++;
        if (none_run >= DB) begin armed = 1; run_len = 0; end
      end else none_run = 0;
    end else if (!hit) run_len = 0;
    else if (run_len == 0) begin run_key = k; run_len = 1; end
    else if (k == run_key) run_len++;
    else run_len = 0;
    if (armed && hit && run_len >= DB) begin
      pend_v = 1; pend_code = run_key; armed = 0; none_run = 0; run_len = 0;
    end
  endtask

  // Drive one frame with a held key mask; kc_off/kl_off pulse kctrl/kclr on
  // that edge of the frame (1..FR, 0 = none). Edge 1 carries any action
  // completed by the previous frame.
  task automatic run_frame(input logic [15:0] mask, input int kc_off, input int kl_off);
    bit ev, com;
    keys = mask;
    for (int off = 1; off <= FR; off++) begin
      ev = 0; com = 0;
      kctrl = (off == kc_off);
      kclr  = (off == kl_off);
      if (off == 1 && pend_v) begin
        ev = 1; pend_v = 0; m_code = pend_code;
        if (pend_code == 4'hE) begin
          com = 1; m_read = m_buf; m_ready = 1; m_buf = 0;
        end else if (pend_code == 4'hF) m_buf = m_buf >> 4;
        else m_buf = {m_buf[11:0], pend_code};
      end
      if (kctrl) begin ev = 1; if (!com) m_ready = 0; end
      if (kclr)  begin ev = 1; m_buf = 0; end
      if (ev) q.push_back('{cyc + 1, m_buf, m_read, m_ready, m_code});
      @(negedge clk);
    end
    kctrl = 0;
    kclr  = 0;
    model_frame(mask);
  endtask

  task automatic press(input logic [3:0] code, input int kc_off, input int kl_off);
    logic [15:0] m;
    m = 16'h0001 << code;
    for (int i = 0; i < DB; i++) run_frame(m, 0, 0);
    run_frame(16'h0000, kc_off, kl_off);
    for (int i = 1; i < DB; i++) run_frame(16'h0000, 0, 0);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: column drive every cycle, and outputs either match the queued
  // snapshot for this edge or are unchanged from the previous cycle.
  initial begin
    logic [15:0] pb, pr;
    logic        prdy;
    logic [3:0]  pkc, ce;
    exp_t        e;
    pb = 0; pr = 0; prdy = 0; pkc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb = 0; pr = 0; prdy = 0; pkc = 0;
      end else begin
        ce = ~(4'b0001 << ((cyc / SD) % 4));
        n_cmp++;
        if (col !== ce) begin
          n_err++;
          $display("FAIL col @%0d: got %b expected %b", cyc, col, ce);
        end
        n_cmp++;
        if (q.size() > 0 && q[0].t == cyc) begin
          e = q.pop_front();
          if (buf_data !== e.b || read_data !== e.r || key_ready !== e.rdy || key_code !== e.kc) begin
            n_err++;
            $display("FAIL action @%0d: got buf=%h read=%h rdy=%b code=%h expected buf=%h read=%h rdy=%b code=%h",
                     cyc, buf_data, read_data, key_ready, key_code, e.b, e.r, e.rdy, e.kc);
          end
        end else if (buf_data !== pb || read_data !== pr || key_ready !== prdy || key_code !== pkc) begin
          n_err++;
          $display("FAIL hold @%0d: got buf=%h read=%h rdy=%b code=%h expected buf=%h read=%h rdy=%b code=%h",
                   cyc, buf_data, read_data, key_ready, key_code, pb, pr, prdy, pkc);
        end
        pb = buf_data; pr = read_data; prdy = key_ready; pkc = key_code;
      end
    end
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout: got no end expected end of stimulus");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    logic [15:0] pk;
    int p, k1, k2;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst col", {12'h0, col}, 16'h000E);
    check("rst read_data", read_data, 16'h0000);
    check("rst key_ready", {15'h0, key_ready}, 16'h0000);
    check("rst buf_data", buf_data, 16'h0000);
    check("rst key_code", {12'h0, key_code}, 16'h0000);
    rst = 1'b0;

    // Idle scanning
    run_frame(16'h0000, 0, 0);
    run_frame(16'h0000, 0, 0);
    check("idle read_data", read_data, 16'h0000);
    check("idle key_ready", {15'h0, key_ready}, 16'h0000);

    // Single digit held 3 frames
    for (int i = 0; i < 3; i++) run_frame(16'h0040, 0, 0);
    run_frame(16'h0000, 0, 0);
    run_frame(16'h0000, 0, 0);
    check("digit6 buf", buf_data, 16'h0006);
    check("digit6 code", {12'h0, key_code}, 16'h0006);

    // Full entry, commit and CPU read
    run_frame(16'h0000, 0, 5);
    for (int d = 1; d <= 5; d++) press(4'(d), 0, 0);
    press(4'hE, 0, 0);
    check("commit read", read_data, 16'h2345);
    check("commit ready", {15'h0, key_ready}, 16'h0001);
    check("commit buf", buf_data, 16'h0000);
    run_frame(16'h0000, 3, 0);
    check("kctrl ready", {15'h0, key_ready}, 16'h0000);
    check("kctrl read", read_data, 16'h2345);

    // Bounce and multi-key rejection
    press(4'h7, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_frame(16'h0008, 0, 0);
      run_frame(16'h0000, 0, 0);
    end
    for (int i = 0; i < 4; i++) run_frame(16'h0081, 0, 0);
    run_frame(16'h0000, 0, 0);
    run_frame(16'h0000, 0, 0);
    check("bounce buf", buf_data, 16'h0007);

    // Backspace, kclr vs digit, commit vs kctrl, overwrite
    run_frame(16'h0000, 0, 1);
    press(4'hA, 0, 0);
    press(4'hB, 0, 0);
    check("AB buf", buf_data, 16'h00AB);
    press(4'hF, 0, 0);
    check("backspace buf", buf_data, 16'h000A);
    press(4'h5, 0, 1);
    check("kclr wins buf", buf_data, 16'h0000);
    check("kclr code", {12'h0, key_code}, 16'h0005);
    press(4'h9, 0, 0);
    press(4'hE, 1, 0);
    check("commit+kctrl ready", {15'h0, key_ready}, 16'h0001);
    check("commit+kctrl read", read_data, 16'h0009);
    press(4'h4, 0, 0);
    press(4'hE, 0, 0);
    check("overwrite read", read_data, 16'h0004);
    check("overwrite ready", {15'h0, key_ready}, 16'h0001);

    // Asynchronous reset in the middle of a debounce
    press(4'h1, 0, 0);
    press(4'h2, 0, 0);
    check("pre-rst buf", buf_data, 16'h0012);
    run_frame(16'h0020, 0, 0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst col", {12'h0, col}, 16'h000E);
    check("arst buf", buf_data, 16'h0000);
    check("arst read", read_data, 16'h0000);
    check("arst ready", {15'h0, key_ready}, 16'h0000);
    check("arst code", {12'h0, key_code}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_frame(16'h0020, 0, 0);
    run_frame(16'h0000, 0, 0);
    run_frame(16'h0000, 0, 0);
    check("post-rst no action", buf_data, 16'h0000);
    press(4'h5, 0, 0);
    check("post-rst press", buf_data, 16'h0005);

    // Randomized frames
    k1 = 3;
    for (int f = 0; f < 150; f++) begin
      p = $urandom_range(0, 99);
      if (p < 35) pk = 16'h0000;
      else if (p < 80) begin
        if ($urandom_range(0, 9) >= 3) pk = 16'h0001 << k1;
        else begin k1 = $urandom_range(0, 15); pk = 16'h0001 << k1; end
      end else if (p < 90) begin
        k2 = (k1 + $urandom_range(1, 15)) % 16;
        pk = (16'h0001 << k1) | (16'h0001 << k2);
      end else begin
        k1 = $urandom_range(0, 15);
        pk = 16'h0001 << k1;
      end
      run_frame(pk,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, FR)) : 0,
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, FR)) : 0);
    end
    for (int i = 0; i < 3; i++) run_frame(16'h0000, 0, 0);

    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
